// File: rtl/mac_seq.sv
// mac_seq: sequential multiply-accumulate producing one scaled dot product per start.
//
// Computes LEN products a*b, keeps only the upper DW bits of each product,
// sums them in an AW-bit accumulator and presents acc[OSH+DW-1:OSH] as the result.
//
// Parameters
//   DW   operand and output width
//   AW   accumulator width (AW >= OSH+DW)
//   LEN  products per dot product (>= 1)
//   OSH  right shift from accumulator to output
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begins a dot product (IDLE only)
//   a, b       unsigned operands
//   in_valid   operand pair present
//   in_ready   operands accepted (ACC only)
//   out        result (valid while out_valid)
//   out_valid  result available (HOLD only)
//   out_ready  consumer takes the result
//   busy       state is not IDLE
//
// Configuration
//   MAC_SAT_EN  when defined, the accumulator clamps at all ones and the output
//               saturates to all ones on overflow; otherwise wrap and truncate.
module mac_seq #(
    parameter int DW  = 8,
    parameter int AW  = 13,
    parameter int LEN = 16,
    parameter int OSH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);
    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   acc, acc_nx, acc_add;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [2*DW-1:0] prod;
    logic [AW-1:0]   hi;
    logic            fire;

    assign prod = a * b;
    assign hi   = AW'(prod[2*DW-1:DW]);
    assign fire = in_valid & in_ready;

`ifdef MAC_SAT_EN
    logic [AW:0] sum;
    logic [AW-1:0] upper;
    assign sum     = {1'b0, acc} + {1'b0, hi};
    assign acc_add = sum[AW] ? '1 : sum[AW-1:0];
    // shift rather than slice so AW == OSH+DW stays legal
    assign upper   = acc >> (OSH + DW);
    assign out     = |upper ? '1 : acc[OSH+DW-1:OSH];
`else
    assign acc_add = acc + hi;
    assign out     = acc[OSH+DW-1:OSH];
`endif

    assign in_ready  = state == ACC;
    assign out_valid = state == HOLD;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (start) begin
                state_nx = ACC;
                acc_nx   = '0;
                cnt_nx   = '0;
            end
            ACC: if (fire) begin
                acc_nx   = acc_add;
                cnt_nx   = cnt + CW'(1);
                state_nx = cnt == CW'(LEN - 1) ? HOLD : ACC;
            end
            HOLD: state_nx = out_ready ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
        end
    end
endmodule
